// File: rtl/id_branch.sv
// id_branch: IF/ID register with control-flow decode, hazard stall and perf counters
module id_branch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_regwrite,
  input  logic        ex_load,
  input  logic [4:0]  ex_wreg,
  input  logic        mem_load,
  input  logic [4:0]  mem_wreg,
  output logic        WritePC,
  output logic        Branch,
  output logic [31:0] BranchAddr,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        out_valid,
  output logic        link,
  output logic [31:0] stall_cnt,
  output logic [31:0] taken_cnt
);
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic        is_beq, is_bne, is_j, is_jal, is_jr, is_cmp;
  logic        use_rs, use_rt, ex_hit, mem_hit, stall, taken;
  logic [31:0] pc4, br_tgt, j_tgt;
  assign op     = id_instr_q[31:26];
  assign rs     = id_instr_q[25:21];
  assign rt     = id_instr_q[20:16];
  assign is_beq = op == 6'b000100;
  assign is_bne = op == 6'b000101;
  assign is_j   = op == 6'b000010;
  assign is_jal = op == 6'b000011;
  assign is_jr  = op == 6'b000000 && id_instr_q[5:0] == 6'b001000;
  assign is_cmp = is_beq | is_bne | is_jr;
  assign use_rs = ~(is_j | is_jal);
  assign use_rt = ~(is_j | is_jal | is_jr);
  assign ex_hit  = ex_wreg != 5'd0 && ((use_rs && ex_wreg == rs) || (use_rt && ex_wreg == rt));
  assign mem_hit = mem_wreg != 5'd0 && ((use_rs && mem_wreg == rs) || (use_rt && mem_wreg == rt));
  assign stall = id_valid_q & ((ex_load & ex_hit) | (is_cmp & ex_regwrite & ex_hit) | (is_cmp & mem_load & mem_hit));
  assign taken = id_valid_q & ~stall & ((is_beq & (rs_data == rt_data)) | (is_bne & (rs_data != rt_data)) | is_j | is_jal | is_jr);
  assign pc4    = id_pc_q + 32'd4;
  assign br_tgt = pc4 + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
  assign j_tgt  = {pc4[31:28], id_instr_q[25:0], 2'b00};
  assign WritePC    = ~stall;
  assign Branch     = taken;
  assign BranchAddr = ~taken ? 32'd0 : is_jr ? rs_data : (is_j | is_jal) ? j_tgt : br_tgt;
  assign out_valid  = id_valid_q & ~stall;
  assign link       = out_valid & is_jal;
  assign id_pc      = id_pc_q;
  assign id_instr   = id_instr_q;
  assign stall_cnt  = stall_cnt_q;
  assign taken_cnt  = taken_cnt_q;
  // next IF/ID contents: hold on stall, otherwise take the redirect target or the fetched pc
  always_comb begin
    id_valid_d  = stall ? id_valid_q : 1'b1;
    id_instr_d  = stall ? id_instr_q : instr;
    id_pc_d     = stall ? id_pc_q : (taken ? BranchAddr : pc);
    stall_cnt_d = stall_cnt_q + 32'(stall);
    taken_cnt_d = taken_cnt_q + 32'(taken);
  end
  // pipeline register and counters, reset discards any held instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q  <= 1'b0;
      id_instr_q  <= 32'd0;
      id_pc_q     <= RESET_PC;
      stall_cnt_q <= 32'd0;
      taken_cnt_q <= 32'd0;
    end else begin
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      stall_cnt_q <= stall_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end
endmodule

// File: tb/tb_id_branch.sv
// tb_id_branch: directed test plan plus randomized run against a behavioural model
module tb_id_branch;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] pc, instr, rs_data, rt_data;
  logic ex_regwrite, ex_load, mem_load;
  logic [4:0] ex_wreg, mem_wreg;
  logic WritePC, Branch, out_valid, link;
  logic [31:0] BranchAddr, id_pc, id_instr, stall_cnt, taken_cnt;
  int checks = 0, failures = 0;
  logic m_valid;
  logic [31:0] m_instr, m_pc, m_scnt, m_tcnt;
  logic e_stall, e_taken;
  logic [31:0] e_addr;

  id_branch dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .ex_regwrite(ex_regwrite), .ex_load(ex_load), .ex_wreg(ex_wreg),
    .mem_load(mem_load), .mem_wreg(mem_wreg), .WritePC(WritePC), .Branch(Branch),
    .BranchAddr(BranchAddr), .id_pc(id_pc), .id_instr(id_instr), .out_valid(out_valid),
    .link(link), .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 other, 1 beq, 2 bne, 3 j, 4 jal, 5 jr
  function automatic int kind_of(input logic [31:0] i);
    case (i[31:26])
      6'd4: return 1;
      6'd5: return 2;
      6'd2: return 3;
      6'd3: return 4;
      6'd0: return (i[5:0] == 6'h08) ? 5 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit uses(input logic [31:0] i, input logic [4:0] r);
    int k = kind_of(i);
    if (r == 0 || k == 3 || k == 4) return 0;
    if (r == i[25:21]) return 1;
    return k != 5 && r == i[20:16];
  endfunction

  function automatic void model_outputs();
    int k = kind_of(m_instr);
    bit cmp = (k == 1 || k == 2 || k == 5);
    logic [31:0] nxt = m_pc + 32'd4;
    logic [31:0] off = 32'($signed(m_instr[15:0])) * 32'd4;
    e_stall = m_valid && ((ex_load && uses(m_instr, ex_wreg)) ||
              (cmp && ex_regwrite && uses(m_instr, ex_wreg)) ||
              (cmp && mem_load && uses(m_instr, mem_wreg)));
    e_taken = m_valid && !e_stall && ((k == 1 && rs_data == rt_data) ||
              (k == 2 && rs_data != rt_data) || k >= 3);
    e_addr = !e_taken ? 32'd0 : (k == 5) ? rs_data :
             (k >= 3) ? {nxt[31:28], m_instr[25:0], 2'b00} : nxt + off;
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic erw, input logic eld, input logic [4:0] ew, input logic mld,
                       input logic [4:0] mw, input logic r);
    @(negedge clk);
    instr = i; pc = p; rs_data = a; rt_data = b; ex_regwrite = erw; ex_load = eld;
    ex_wreg = ew; mem_load = mld; mem_wreg = mw; rst = r;
    #1;
    model_outputs();
    check("WritePC", 32'(WritePC), 32'(!e_stall));
    check("Branch", 32'(Branch), 32'(e_taken));
    check("BranchAddr", BranchAddr, e_addr);
    check("out_valid", 32'(out_valid), 32'(m_valid && !e_stall));
    check("link", 32'(link), 32'(m_valid && !e_stall && kind_of(m_instr) == 4));
    check("id_pc", id_pc, m_pc);
    check("id_instr", id_instr, m_instr);
    check("stall_cnt", stall_cnt, m_scnt);
    check("taken_cnt", taken_cnt, m_tcnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_instr = 0; m_pc = 32'h3000; m_scnt = 0; m_tcnt = 0;
    end else begin
      if (e_stall) m_scnt++;
      else begin
        m_instr = instr; m_pc = e_taken ? e_addr : pc; m_valid = 1;
      end
      if (e_taken) m_tcnt++;
    end
  endtask

  task automatic go(input logic [31:0] i, input logic [31:0] p);
    drive(i, p, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    instr = 0; pc = 32'h3000; rs_data = 0; rt_data = 0; ex_regwrite = 0; ex_load = 0;
    ex_wreg = 0; mem_load = 0; mem_wreg = 0;
    repeat (2) @(posedge clk);
    m_valid = 0; m_instr = 0; m_pc = 32'h3000; m_scnt = 0; m_tcnt = 0;
    drive(0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_BranchAddr", BranchAddr, 0);
    check("rst_id_pc", id_pc, 32'h3000);
    tick();
    go(0, 32'h3000);
    check("first_id_pc", id_pc, 32'h3000);
    go(32'h1022_0003, 32'h3004);
    drive(0, 32'h3008, 5, 5, 0, 0, 0, 0, 0, 0);
    check("beq_Branch", 32'(Branch), 1);
    check("beq_addr", BranchAddr, 32'h3014);
    tick();
    #1 check("beq_next_pc", id_pc, 32'h3014);
    check("beq_taken_cnt", taken_cnt, 1);
    go(32'h1422_FFFF, 32'h3018);
    drive(0, 32'h301C, 1, 2, 0, 0, 0, 0, 0, 0);
    check("bne_addr", BranchAddr, 32'h3018);
    tick();
    go(32'h0065_2020, 32'h3020);
    drive(0, 32'h3024, 0, 0, 1, 1, 3, 0, 0, 0);
    check("lu_WritePC", 32'(WritePC), 0);
    tick();
    #1 check("lu_held", id_instr, 32'h0065_2020);
    check("lu_stall_cnt", stall_cnt, 1);
    go(0, 32'h3024);
    go(32'h03E0_0008, 32'h3028);
    drive(0, 32'h302C, 32'h3100, 0, 0, 0, 0, 1, 31, 0);
    check("jr_stall", 32'(WritePC), 0);
    tick();
    drive(0, 32'h302C, 32'h3100, 0, 0, 0, 0, 0, 0, 0);
    check("jr_addr", BranchAddr, 32'h3100);
    tick();
    go(32'h0C00_0C00, 32'h3104);
    drive(0, 32'h3108, 0, 0, 0, 1, 0, 0, 0, 0);
    check("jal_link", 32'(link), 1);
    check("jal_addr", BranchAddr, 32'h3000);
    tick();
    go(32'h0065_2020, 32'h3004);
    drive(0, 32'h3008, 0, 0, 1, 1, 3, 0, 0, 1);
    tick();
    drive(0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_valid", 32'(out_valid), 0);
    check("rst_mid_scnt", stall_cnt, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ri;
      int k = $urandom_range(0, 5);
      ri = $urandom;
      ri[25:16] = {3'b0, 2'($urandom_range(0, 3)), 3'b0, 2'($urandom_range(0, 3))};
      ri[31:26] = (k == 1) ? 6'd4 : (k == 2) ? 6'd5 : (k == 3) ? 6'd2 : (k == 4) ? 6'd3 : 6'd0;
      if (k == 5) ri[5:0] = 6'h08;
      drive(ri, {$urandom, 2'b00} >> 2 << 2, 32'($urandom_range(0, 2)), 32'($urandom_range(0, 2)),
            1'($urandom), 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 99) == 0));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
